// File: rtl/core_mem_responder.sv
// Memory responder for one core: preloads a program image from a host, then serves fetches, loads and stores.
// Fetch and load reads are combinational and have zero latency. Stores and preload writes land at the next rising edge.
// The core is held in reset (core_hold_o) until the host signals done. host_rdy_o is high for the whole preload phase.
module core_mem_responder #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4096,
  parameter logic [XLEN-1:0] BASE_ADR = 32'h0
) (
  input  logic            clk,
  input  logic            reset,
  // host preload port
  input  logic            host_v_i,
  input  logic [31:0]     host_data_i,
  input  logic            host_done_i,
  output logic            host_rdy_o,
  output logic            core_hold_o,
  // instruction fetch port
  input  logic [XLEN-1:0] icache_adr_i,
  output logic [31:0]     icache_instr_o,
  // data port
  input  logic            adr_v_i,
  input  logic [XLEN-1:0] adr_i,
  input  logic [XLEN-1:0] is_store_i,
  input  logic [XLEN-1:0] store_data_i,
  input  logic [2:0]      access_size_i,
  output logic [XLEN-1:0] load_data_o,
  // status
  output logic            err_v_q_o,
  output logic [1:0]      err_code_q_o,
  output logic [XLEN-1:0] err_adr_q_o,
  output logic [31:0]     store_cnt_q_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = $clog2(DEPTH + 1);
  localparam logic [XLEN-1:0] DEPTH_X  = XLEN'(DEPTH);
  localparam logic [PW-1:0]   PTR_FULL = PW'(DEPTH);
  localparam logic [31:0]     NOP      = 32'h0000_0013;

  localparam logic [1:0] ERR_MISALIGN = 2'd1;
  localparam logic [1:0] ERR_RANGE    = 2'd2;
  localparam logic [1:0] ERR_SIZE     = 2'd3;

  typedef enum logic {
    S_LOAD = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t            state;
  logic [PW-1:0]     ptr_q;
  logic              hold_q;
  logic              rdy_q;
  logic              err_v_q;
  logic [1:0]        err_code_q;
  logic [XLEN-1:0]   err_adr_q;
  logic [31:0]       store_cnt_q;

  logic [XLEN-1:0]   mem [DEPTH];

  // address decode
  logic [XLEN-1:0]   f_idx;
  logic              f_in_range;
  logic [XLEN-1:0]   d_idx;
  logic              d_in_range;

  // data-port decode
  logic              run;
  logic              is_st;
  logic [1:0]        lane;
  logic              sz_byte;
  logic              sz_half;
  logic              sz_word;
  logic              bad_size;
  logic              misaligned;
  logic              d_err;
  logic [1:0]        d_err_code;
  logic [XLEN-1:0]   rd_word;
  logic [XLEN-1:0]   wr_mask;
  logic [XLEN-1:0]   wr_data;
  logic [XLEN-1:0]   st_word;
  logic              pre_we;
  logic              st_we;

  assign run = (state == S_RUN);

  // Word index is taken relative to the base; below-base addresses wrap to a huge index
  // but are also caught explicitly so the range check never depends on the wrap.
  assign f_idx      = (icache_adr_i - BASE_ADR) >> 2;
  assign f_in_range = (icache_adr_i >= BASE_ADR) && (f_idx < DEPTH_X);
  assign d_idx      = (adr_i - BASE_ADR) >> 2;
  assign d_in_range = (adr_i >= BASE_ADR) && (d_idx < DEPTH_X);

  // Fetch path: live in both states so the host image can be observed while the core is held.
  always_comb begin
    icache_instr_o = NOP;
    if (f_in_range) begin
      icache_instr_o = mem[f_idx[AW-1:0]];
    end
  end

  // Data-port decode: size/alignment/range classification, load extraction and store lane merge.
  always_comb begin
    is_st    = |is_store_i;
    lane     = adr_i[1:0];
    sz_byte  = (access_size_i == 3'b001);
    sz_half  = (access_size_i == 3'b010);
    sz_word  = (access_size_i == 3'b100);
    bad_size = !(sz_byte || sz_half || sz_word);
    misaligned = (sz_half && lane[0]) || (sz_word && (lane != 2'b00));
    d_err    = run && adr_v_i && (bad_size || misaligned || !d_in_range);

    // bad size outranks misalignment, which outranks range
    d_err_code = ERR_RANGE;
    if (bad_size) begin
      d_err_code = ERR_SIZE;
    end else if (misaligned) begin
      d_err_code = ERR_MISALIGN;
    end

    rd_word = '0;
    if (d_in_range) begin
      rd_word = mem[d_idx[AW-1:0]];
    end

    load_data_o = '0;
    if (run && adr_v_i && !is_st && !d_err) begin
      if (sz_byte) begin
        load_data_o = XLEN'(rd_word[{lane, 3'b000} +: 8]);
      end else if (sz_half) begin
        load_data_o = XLEN'(rd_word[{lane[1], 4'b0000} +: 16]);
      end else begin
        load_data_o = rd_word;
      end
    end

    wr_mask = '0;
    wr_data = '0;
    if (sz_byte) begin
      wr_mask = XLEN'(32'h0000_00FF) << {lane, 3'b000};
      wr_data = {(XLEN/8){store_data_i[7:0]}};
    end else if (sz_half) begin
      wr_mask = XLEN'(32'h0000_FFFF) << {lane[1], 4'b0000};
      wr_data = {(XLEN/16){store_data_i[15:0]}};
    end else if (sz_word) begin
      wr_mask = '1;
      wr_data = store_data_i;
    end
    st_word = (rd_word & ~wr_mask) | (wr_data & wr_mask);

    pre_we = !reset && !run && host_v_i && (ptr_q != PTR_FULL);
    st_we  = !reset && run && adr_v_i && is_st && !d_err;
  end

  // Word array: preload writes in LOAD, merged stores in RUN; never reset so an image survives a core reset.
  always_ff @(posedge clk) begin
    if (pre_we) begin
      mem[ptr_q[AW-1:0]] <= host_data_i;
    end else if (st_we) begin
      mem[d_idx[AW-1:0]] <= st_word;
    end
  end

  // Control FSM: preload pointer, core hold, sticky first-error capture and store counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_LOAD;
      ptr_q       <= '0;
      hold_q      <= 1'b1;
      rdy_q       <= 1'b1;
      err_v_q     <= 1'b0;
      err_code_q  <= 2'd0;
      err_adr_q   <= '0;
      store_cnt_q <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          if (host_v_i) begin
            if (ptr_q != PTR_FULL) begin
              ptr_q <= ptr_q + 1'b1;
            end else if (!err_v_q) begin
              // array full: word is dropped, report where it would have gone
              err_v_q    <= 1'b1;
              err_code_q <= ERR_SIZE;
              err_adr_q  <= BASE_ADR + (XLEN'(ptr_q) << 2);
            end
          end
          if (host_done_i) begin
            state  <= S_RUN;
            hold_q <= 1'b0;
            rdy_q  <= 1'b0;
          end
        end
        S_RUN: begin
          if (d_err && !err_v_q) begin
            err_v_q    <= 1'b1;
            err_code_q <= d_err_code;
            err_adr_q  <= adr_i;
          end
          if (st_we) begin
            store_cnt_q <= store_cnt_q + 32'd1;
          end
        end
        default: begin
          state <= S_LOAD;
        end
      endcase
    end
  end

  assign host_rdy_o    = rdy_q;
  assign core_hold_o   = hold_q;
  assign err_v_q_o     = err_v_q;
  assign err_code_q_o  = err_code_q;
  assign err_adr_q_o   = err_adr_q;
  assign store_cnt_q_o = store_cnt_q;

endmodule

// File: tb/tb_core_mem_responder.sv
// Directed bench for core_mem_responder: preload, loads/stores, errors, overflow, reset.
// Inputs change 1 ns after the rising edge; outputs are sampled before the next edge.
// Small array (16 words) at a non-zero base so range edges are reachable.
module tb_core_mem_responder;

  localparam int          XLEN  = 32;
  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset;
  logic        host_v;
  logic [31:0] host_data;
  logic        host_done;
  logic        host_rdy;
  logic        core_hold;
  logic [31:0] icache_adr;
  logic [31:0] icache_instr;
  logic        adr_v;
  logic [31:0] adr;
  logic [31:0] is_store;
  logic [31:0] store_data;
  logic [2:0]  access_size;
  logic [31:0] load_data;
  logic        err_v;
  logic [1:0]  err_code;
  logic [31:0] err_adr;
  logic [31:0] store_cnt;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  core_mem_responder #(.XLEN(XLEN), .DEPTH(DEPTH), .BASE_ADR(BASE)) dut (
    .clk(clk), .reset(reset),
    .host_v_i(host_v), .host_data_i(host_data), .host_done_i(host_done),
    .host_rdy_o(host_rdy), .core_hold_o(core_hold),
    .icache_adr_i(icache_adr), .icache_instr_o(icache_instr),
    .adr_v_i(adr_v), .adr_i(adr), .is_store_i(is_store), .store_data_i(store_data),
    .access_size_i(access_size), .load_data_o(load_data),
    .err_v_q_o(err_v), .err_code_q_o(err_code), .err_adr_q_o(err_adr),
    .store_cnt_q_o(store_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    host_v = 1'b0; host_data = '0; host_done = 1'b0;
    adr_v = 1'b0; adr = '0; is_store = '0; store_data = '0; access_size = 3'b100;
  endtask

  task automatic reset_to_run();
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
    host_done = 1'b1;
    step();
    host_done = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    icache_adr = BASE;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
    checks++; if (core_hold !== 1'b1) $display("FAIL reset_hold got %b exp 1", core_hold); else passed++;
    checks++; if (host_rdy !== 1'b1) $display("FAIL reset_rdy got %b exp 1", host_rdy); else passed++;
    checks++; if (err_v !== 1'b0) $display("FAIL reset_err_v got %b exp 0", err_v); else passed++;
    checks++; if (err_code !== 2'd0) $display("FAIL reset_err_code got %0d exp 0", err_code); else passed++;
    checks++; if (err_adr !== 32'h0) $display("FAIL reset_err_adr got %h exp 0", err_adr); else passed++;
    checks++; if (store_cnt !== 32'h0) $display("FAIL reset_cnt got %0d exp 0", store_cnt); else passed++;
  endtask

  task automatic test_preload();
    // first word, with a store attempt on the data port that must be ignored
    host_v = 1'b1; host_data = 32'h1111_1111;
    adr_v = 1'b1; is_store = 32'h1; adr = BASE; access_size = 3'b100; store_data = 32'hFFFF_FFFF;
    #1;
    checks++; if (load_data !== 32'h0) $display("FAIL preload_load_zero got %h exp 0", load_data); else passed++;
    step();
    host_data = 32'h2222_2222; host_done = 1'b1;
    adr_v = 1'b0; is_store = '0;
    #1;
    checks++; if (core_hold !== 1'b1) $display("FAIL preload_hold_during_done got %b exp 1", core_hold); else passed++;
    step();
    idle();
    checks++; if (core_hold !== 1'b0) $display("FAIL preload_hold_after got %b exp 0", core_hold); else passed++;
    checks++; if (host_rdy !== 1'b0) $display("FAIL preload_rdy_after got %b exp 0", host_rdy); else passed++;
    checks++; if (store_cnt !== 32'h0) $display("FAIL preload_cnt got %0d exp 0", store_cnt); else passed++;
    icache_adr = BASE; #1;
    checks++; if (icache_instr !== 32'h1111_1111) $display("FAIL preload_mem0 got %h exp 11111111", icache_instr); else passed++;
    icache_adr = BASE + 32'd4; #1;
    checks++; if (icache_instr !== 32'h2222_2222) $display("FAIL preload_mem1 got %h exp 22222222", icache_instr); else passed++;
  endtask

  task automatic test_byte_store();
    adr_v = 1'b1; is_store = 32'h8000_0000; adr = BASE + 32'd5; access_size = 3'b001;
    store_data = 32'h1234_56AB;
    step();
    is_store = '0; adr = BASE + 32'd4; access_size = 3'b100; #1;
    checks++; if (load_data !== 32'h2222_AB22) $display("FAIL sb_lw got %h exp 2222ab22", load_data); else passed++;
    checks++; if (store_cnt !== 32'd1) $display("FAIL sb_cnt got %0d exp 1", store_cnt); else passed++;
    adr = BASE + 32'd5; access_size = 3'b001; #1;
    checks++; if (load_data !== 32'h0000_00AB) $display("FAIL sb_lb got %h exp ab", load_data); else passed++;
    adr_v = 1'b0; #1;
    checks++; if (load_data !== 32'h0) $display("FAIL idle_load_zero got %h exp 0", load_data); else passed++;
  endtask

  task automatic test_half();
    adr_v = 1'b1; is_store = 32'h1; adr = BASE + 32'd2; access_size = 3'b010;
    store_data = 32'h0000_BEEF;
    step();
    is_store = '0; #1;
    checks++; if (load_data !== 32'h0000_BEEF) $display("FAIL sh_lh got %h exp beef", load_data); else passed++;
    adr = BASE + 32'd3; access_size = 3'b001; #1;
    checks++; if (load_data !== 32'h0000_00BE) $display("FAIL sh_lb got %h exp be", load_data); else passed++;
    adr = BASE; access_size = 3'b100; #1;
    checks++; if (load_data !== 32'hBEEF_1111) $display("FAIL sh_lw got %h exp beef1111", load_data); else passed++;
    access_size = 3'b010; #1;
    checks++; if (load_data !== 32'h0000_1111) $display("FAIL sh_lh_low got %h exp 1111", load_data); else passed++;
    checks++; if (store_cnt !== 32'd2) $display("FAIL sh_cnt got %0d exp 2", store_cnt); else passed++;
    adr_v = 1'b0;
  endtask

  task automatic test_read_during_write();
    adr_v = 1'b1; is_store = 32'h1; adr = BASE + 32'd8; access_size = 3'b100;
    store_data = 32'h5555_5555;
    step();
    store_data = 32'hDEAD_BEEF; icache_adr = BASE + 32'd8; #1;
    checks++; if (icache_instr !== 32'h5555_5555) $display("FAIL rdw_old got %h exp 55555555", icache_instr); else passed++;
    step();
    adr_v = 1'b0; is_store = '0; #1;
    checks++; if (icache_instr !== 32'hDEAD_BEEF) $display("FAIL rdw_new got %h exp deadbeef", icache_instr); else passed++;
    checks++; if (store_cnt !== 32'd4) $display("FAIL rdw_cnt got %0d exp 4", store_cnt); else passed++;
    icache_adr = BASE + 32'd64; #1;
    checks++; if (icache_instr !== 32'h0000_0013) $display("FAIL fetch_oor_hi got %h exp 13", icache_instr); else passed++;
    icache_adr = BASE - 32'd4; #1;
    checks++; if (icache_instr !== 32'h0000_0013) $display("FAIL fetch_oor_lo got %h exp 13", icache_instr); else passed++;
    checks++; if (err_v !== 1'b0) $display("FAIL fetch_no_err got %b exp 0", err_v); else passed++;
  endtask

  task automatic test_error();
    adr_v = 1'b1; is_store = '0; adr = BASE + 32'd6; access_size = 3'b100; #1;
    checks++; if (load_data !== 32'h0) $display("FAIL mis_load_zero got %h exp 0", load_data); else passed++;
    step();
    checks++; if (err_v !== 1'b1) $display("FAIL mis_err_v got %b exp 1", err_v); else passed++;
    checks++; if (err_code !== 2'd1) $display("FAIL mis_code got %0d exp 1", err_code); else passed++;
    checks++; if (err_adr !== BASE + 32'd6) $display("FAIL mis_adr got %h exp %h", err_adr, BASE + 32'd6); else passed++;
    // out-of-range store: dropped, first error retained
    is_store = 32'h1; adr = BASE + 32'd64; store_data = 32'h0;
    step();
    checks++; if (err_code !== 2'd1) $display("FAIL sticky_code got %0d exp 1", err_code); else passed++;
    checks++; if (err_adr !== BASE + 32'd6) $display("FAIL sticky_adr got %h exp %h", err_adr, BASE + 32'd6); else passed++;
    // bad-size store over word 0: must not land
    adr = BASE; access_size = 3'b011;
    step();
    is_store = '0; access_size = 3'b100; #1;
    checks++; if (load_data !== 32'hBEEF_1111) $display("FAIL badsize_dropped got %h exp beef1111", load_data); else passed++;
    checks++; if (store_cnt !== 32'd4) $display("FAIL err_cnt got %0d exp 4", store_cnt); else passed++;
    adr_v = 1'b0;
  endtask

  task automatic test_priority();
    reset_to_run();
    adr_v = 1'b1; is_store = 32'h1; adr = BASE + 32'd1; access_size = 3'b011;
    step();
    checks++; if (err_code !== 2'd3) $display("FAIL prio_size got %0d exp 3", err_code); else passed++;
    checks++; if (err_adr !== BASE + 32'd1) $display("FAIL prio_size_adr got %h exp %h", err_adr, BASE + 32'd1); else passed++;
    reset_to_run();
    adr_v = 1'b1; is_store = '0; adr = BASE + 32'd65; access_size = 3'b010;
    step();
    checks++; if (err_code !== 2'd1) $display("FAIL prio_mis got %0d exp 1", err_code); else passed++;
    reset_to_run();
    adr_v = 1'b1; is_store = '0; adr = BASE - 32'd1; access_size = 3'b001; #1;
    checks++; if (load_data !== 32'h0) $display("FAIL oor_load_zero got %h exp 0", load_data); else passed++;
    step();
    checks++; if (err_code !== 2'd2) $display("FAIL prio_range got %0d exp 2", err_code); else passed++;
    checks++; if (err_adr !== BASE - 32'd1) $display("FAIL range_adr got %h exp %h", err_adr, BASE - 32'd1); else passed++;
    idle();
  endtask

  task automatic test_overflow();
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      host_v = 1'b1; host_data = 32'hA000_0000 + i;
      step();
    end
    host_data = 32'hFFFF_FFFF; host_done = 1'b1; #1;
    checks++; if (err_v !== 1'b0) $display("FAIL ovf_not_yet got %b exp 0", err_v); else passed++;
    step();
    idle();
    checks++; if (err_v !== 1'b1) $display("FAIL ovf_err_v got %b exp 1", err_v); else passed++;
    checks++; if (err_code !== 2'd3) $display("FAIL ovf_code got %0d exp 3", err_code); else passed++;
    checks++; if (err_adr !== BASE + 32'd64) $display("FAIL ovf_adr got %h exp %h", err_adr, BASE + 32'd64); else passed++;
    checks++; if (core_hold !== 1'b0) $display("FAIL ovf_hold got %b exp 0", core_hold); else passed++;
    icache_adr = BASE + 32'd60; #1;
    checks++; if (icache_instr !== 32'hA000_000F) $display("FAIL ovf_last got %h exp a000000f", icache_instr); else passed++;
    icache_adr = BASE; #1;
    checks++; if (icache_instr !== 32'hA000_0000) $display("FAIL ovf_no_wrap got %h exp a0000000", icache_instr); else passed++;
    // reset while running: core held again, status cleared, image kept
    reset = 1'b1;
    step();
    reset = 1'b0;
    icache_adr = BASE + 32'd4; #1;
    checks++; if (core_hold !== 1'b1) $display("FAIL rst_run_hold got %b exp 1", core_hold); else passed++;
    checks++; if (err_v !== 1'b0) $display("FAIL rst_run_err got %b exp 0", err_v); else passed++;
    checks++; if (icache_instr !== 32'hA000_0001) $display("FAIL rst_run_mem got %h exp a0000001", icache_instr); else passed++;
  endtask

  initial begin
    reset = 1'b1;
    icache_adr = BASE;
    idle();
    test_reset();
    test_preload();
    test_byte_store();
    test_half();
    test_read_during_write();
    test_error();
    test_priority();
    test_overflow();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
